// File: rtl/tia_horizontal_decoder_pkg.sv
// Shared constants for the TIA horizontal decoder: LFSR sequence, decode states, line timing.
// Decode constants are derived from the same 6-bit XNOR LFSR that drives the line counter.
package tia_horizontal_pkg;

    localparam int unsigned LINE_TICKS    = 57;
    localparam int unsigned CLKS_PER_TICK = 4;

    localparam int unsigned K_SHS  = 4;
    localparam int unsigned K_RHS  = 8;
    localparam int unsigned K_RCB  = 12;
    localparam int unsigned K_RHB  = 16;
    localparam int unsigned K_LRHB = 18;
    localparam int unsigned K_CNT  = 36;

    // Taps 6,5 with XNOR feedback; reset state 000000, all-ones is the lockup state.
    function automatic logic [5:0] lfsr_step(input logic [5:0] s);
        return {s[4:0], ~(s[5] ^ s[4])};
    endfunction

    function automatic logic [5:0] lfsr_at(input int unsigned k);
        logic [5:0] s;
        s = '0;
        for (int unsigned i = 0; i < k; i++) begin
            s = lfsr_step(s);
        end
        return s;
    endfunction

    localparam logic [5:0] HD_SHS  = lfsr_at(K_SHS);
    localparam logic [5:0] HD_RHS  = lfsr_at(K_RHS);
    localparam logic [5:0] HD_RCB  = lfsr_at(K_RCB);
    localparam logic [5:0] HD_RHB  = lfsr_at(K_RHB);
    localparam logic [5:0] HD_LRHB = lfsr_at(K_LRHB);
    localparam logic [5:0] HD_CNT  = lfsr_at(K_CNT);

    typedef struct packed {
        logic shs;
        logic rhs;
        logic rcb;
        logic rhb;
        logic lrhb;
        logic cnt;
    } hdec_events_t;

endpackage

// File: rtl/tia_horizontal_decoder_if.sv
// Horizontal timing bus: LFSR tick/state and CPU strobes in, decoded line timing out.
interface tia_horizontal_decoder_if;

    logic       hphi_tick;
    logic [5:0] lfsr;
    logic       shb;
    logic       hmove;
    logic       wsync;

    logic       hsync;
    logic       hblank;
    logic       cburst;
    logic       center;
    logic       rdy;
    logic       line_start;

    modport master (
        output hphi_tick, lfsr, shb, hmove, wsync,
        input  hsync, hblank, cburst, center, rdy, line_start
    );

    modport slave (
        input  hphi_tick, lfsr, shb, hmove, wsync,
        output hsync, hblank, cburst, center, rdy, line_start
    );

endinterface

// File: rtl/tia_horizontal_match.sv
// Combinational LFSR-state matcher: flags which horizontal decode event the current state hits.
module tia_horizontal_match
    import tia_horizontal_pkg::*;
(
    input  logic [5:0]   lfsr,
    output hdec_events_t events
);

    always_comb begin
        events      = '0;
        events.shs  = (lfsr == HD_SHS);
        events.rhs  = (lfsr == HD_RHS);
        events.rcb  = (lfsr == HD_RCB);
        events.rhb  = (lfsr == HD_RHB);
        events.lrhb = (lfsr == HD_LRHB);
        events.cnt  = (lfsr == HD_CNT);
    end

endmodule

// File: rtl/tia_horizontal_decoder.sv
// TIA horizontal decoder: turns LFSR ticks into registered sync/blank/burst/centre timing,
// plus the HMOVE blank-extension latch and WSYNC-driven CPU ready.
module tia_horizontal_decoder
    import tia_horizontal_pkg::*;
#(
    parameter bit HMOVE_EXTEND = 1'b1
)
(
    input logic                     clk,
    input logic                     reset,
    tia_horizontal_decoder_if.slave bus
);

    hdec_events_t ev;
    logic         hmove_latch;
    logic         tick;
    logic         wrap;
    logic         hb_clear;

    tia_horizontal_match u_match (
        .lfsr   (bus.lfsr),
        .events (ev)
    );

    always_comb begin
        tick     = bus.hphi_tick;
        wrap     = bus.hphi_tick & bus.shb;
        hb_clear = '0;
        if (tick) begin
            hb_clear = (HMOVE_EXTEND && hmove_latch) ? ev.lrhb : ev.rhb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.hblank     <= 1'b1;
            bus.hsync      <= 1'b0;
            bus.cburst     <= 1'b0;
            bus.center     <= 1'b0;
            bus.rdy        <= 1'b1;
            bus.line_start <= 1'b0;
            hmove_latch    <= 1'b0;
        end else begin
            bus.line_start <= wrap;

            // A new HMOVE on the clearing tick wins, so the extension carries into the next line.
            if (bus.hmove) begin
                hmove_latch <= 1'b1;
            end else if (hb_clear) begin
                hmove_latch <= 1'b0;
            end

            if (wrap) begin
                bus.rdy <= ~bus.wsync;
            end else if (bus.wsync) begin
                bus.rdy <= 1'b0;
            end

            if (tick) begin
                if (wrap) begin
                    bus.hblank <= 1'b1;
                end else if (hb_clear) begin
                    bus.hblank <= 1'b0;
                end

                if (ev.shs) begin
                    bus.hsync <= 1'b1;
                end else if (ev.rhs) begin
                    bus.hsync <= 1'b0;
                end

                if (ev.rhs) begin
                    bus.cburst <= 1'b1;
                end else if (ev.rcb) begin
                    bus.cburst <= 1'b0;
                end

                if (wrap) begin
                    bus.center <= 1'b0;
                end else if (ev.cnt) begin
                    bus.center <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tia_horizontal_decoder.sv
// Directed bench for tia_horizontal_decoder: one instance with HMOVE extension, one without,
// driven in lockstep from a behavioural horizontal LFSR.
module tb_tia_horizontal_decoder;

    logic       clk;
    logic       reset;
    logic       hphi_tick;
    logic [5:0] lfsr;
    logic       shb;
    logic       hmove;
    logic       wsync;

    tia_horizontal_decoder_if bus0 ();
    tia_horizontal_decoder_if bus1 ();

    assign bus0.hphi_tick = hphi_tick;
    assign bus0.lfsr      = lfsr;
    assign bus0.shb       = shb;
    assign bus0.hmove     = hmove;
    assign bus0.wsync     = wsync;
    assign bus1.hphi_tick = hphi_tick;
    assign bus1.lfsr      = lfsr;
    assign bus1.shb       = shb;
    assign bus1.hmove     = hmove;
    assign bus1.wsync     = wsync;

    tia_horizontal_decoder #(.HMOVE_EXTEND(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    tia_horizontal_decoder #(.HMOVE_EXTEND(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // {hsync, hblank, cburst, center, rdy, line_start}
    logic [5:0] out0;
    logic [5:0] out1;
    assign out0 = {bus0.hsync, bus0.hblank, bus0.cburst, bus0.center, bus0.rdy, bus0.line_start};
    assign out1 = {bus1.hsync, bus1.hblank, bus1.cburst, bus1.center, bus1.rdy, bus1.line_start};

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    int unsigned phase = 0;
    int unsigned cur   = 0;
    logic [5:0]  lfsr_tab [57];

    typedef struct {
        int unsigned k;
        logic [5:0]  exp;
    } vec_t;
    vec_t tbl [13];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [5:0] e0, input logic [5:0] e1);
        total++;
        if (out0 !== e0) begin
            bad++;
            $display("FAIL %s ext1 got=%b exp=%b", name, out0, e0);
        end
        total++;
        if (out1 !== e1) begin
            bad++;
            $display("FAIL %s ext0 got=%b exp=%b", name, out1, e1);
        end
    endtask

    task automatic check_num(input string name, input int unsigned got, input int unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Non-tick cycles carry junk lfsr and a stray shb to prove both are qualified by the tick.
    task automatic cycle(input bit hm, input bit ws);
        hphi_tick = (phase == 0);
        lfsr      = (phase == 0) ? lfsr_tab[cur] : 6'($urandom);
        shb       = (phase == 0) ? (cur == 56) : (phase == 2);
        hmove     = hm;
        wsync     = ws;
        @(posedge clk);
        #1;
        hphi_tick = 1'b0;
        shb       = 1'b0;
        hmove     = 1'b0;
        wsync     = 1'b0;
        cyc++;
        if (phase == 0) cur = (cur == 56) ? 0 : cur + 1;
        phase = (phase + 1) % 4;
    endtask

    task automatic go_tick(input int unsigned k, input bit hm, input bit ws);
        int unsigned guard;
        guard = 0;
        while (!(phase == 0 && cur == k)) begin
            cycle(1'b0, 1'b0);
            guard++;
            if (guard > 300) begin
                total++;
                bad++;
                $display("FAIL go_tick_%0d got=timeout exp=reached", k);
                return;
            end
        end
        cycle(hm, ws);
    endtask

    task automatic raw_tick(input logic [5:0] v, input bit s);
        while (phase != 0) cycle(1'b0, 1'b0);
        hphi_tick = 1'b1;
        lfsr      = v;
        shb       = s;
        @(posedge clk);
        #1;
        hphi_tick = 1'b0;
        shb       = 1'b0;
        cyc++;
        phase = 1;
        if (s) cur = 0;
    endtask

    initial begin : main
        logic [5:0]  s;
        int unsigned c1;
        int unsigned c2;
        int unsigned n;

        s = '0;
        for (int i = 0; i < 57; i++) begin
            lfsr_tab[i] = s;
            s = {s[4:0], ~(s[5] ^ s[4])};
        end

        tbl[0]  = '{0,  6'b010010};
        tbl[1]  = '{3,  6'b010010};
        tbl[2]  = '{4,  6'b110010};
        tbl[3]  = '{7,  6'b110010};
        tbl[4]  = '{8,  6'b011010};
        tbl[5]  = '{11, 6'b011010};
        tbl[6]  = '{12, 6'b010010};
        tbl[7]  = '{15, 6'b010010};
        tbl[8]  = '{16, 6'b000010};
        tbl[9]  = '{35, 6'b000010};
        tbl[10] = '{36, 6'b000110};
        tbl[11] = '{55, 6'b000110};
        tbl[12] = '{56, 6'b010011};

        reset = 1'b1; hphi_tick = 1'b0; lfsr = '0; shb = 1'b0; hmove = 1'b0; wsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 6'b010010, 6'b010010);
        reset = 1'b0;
        phase = 0;
        cur   = 0;

        for (int i = 0; i < 13; i++) begin
            go_tick(tbl[i].k, 1'b0, 1'b0);
            check($sformatf("line0_k%0d", tbl[i].k), tbl[i].exp, tbl[i].exp);
        end
        c1 = cyc;
        cycle(1'b0, 1'b0);
        check("line_start_width", 6'b010010, 6'b010010);

        // HMOVE early in the line: extended blank on dut0 only.
        go_tick(2, 1'b1, 1'b0);
        check("hmove_k2", 6'b010010, 6'b010010);
        go_tick(16, 1'b0, 1'b0);
        check("hmove_k16", 6'b010010, 6'b000010);
        go_tick(17, 1'b0, 1'b0);
        check("hmove_k17", 6'b010010, 6'b000010);
        go_tick(18, 1'b0, 1'b0);
        check("hmove_k18", 6'b000010, 6'b000010);
        go_tick(56, 1'b0, 1'b0);
        c2 = cyc;
        check("hmove_wrap", 6'b010011, 6'b010011);
        check_num("line_period_clks", c2 - c1, 228);
        go_tick(16, 1'b0, 1'b0);
        check("latch_cleared_k16", 6'b000010, 6'b000010);

        // HMOVE coincident with the LRHB tick re-arms the latch for the next line.
        go_tick(2, 1'b1, 1'b0);
        go_tick(18, 1'b1, 1'b0);
        check("hmove_at_lrhb", 6'b000010, 6'b000010);
        go_tick(16, 1'b0, 1'b0);
        check("persist_k16", 6'b010010, 6'b000010);
        go_tick(18, 1'b0, 1'b0);
        check("persist_k18", 6'b000010, 6'b000010);
        go_tick(16, 1'b0, 1'b0);
        check("persist_cleared_k16", 6'b000010, 6'b000010);

        go_tick(30, 1'b0, 1'b1);
        check("wsync_k30", 6'b000000, 6'b000000);
        go_tick(36, 1'b0, 1'b0);
        check("wsync_k36", 6'b000100, 6'b000100);
        go_tick(55, 1'b0, 1'b0);
        check("wsync_k55", 6'b000100, 6'b000100);
        go_tick(56, 1'b0, 1'b0);
        check("wsync_release", 6'b010011, 6'b010011);

        go_tick(56, 1'b0, 1'b1);
        check("wsync_on_wrap", 6'b010001, 6'b010001);
        n = 1;
        while (bus0.rdy !== 1'b1 && n < 400) begin
            cycle(1'b0, 1'b0);
            if (bus0.rdy !== 1'b1) n++;
        end
        check_num("wsync_wrap_low_clks", n, 228);
        check("wsync_wrap_release", 6'b010011, 6'b010011);

        // Reset mid-line with every strobe asserted, including a wrap tick on SHS.
        go_tick(6, 1'b0, 1'b0);
        check("pre_reset_k6", 6'b110010, 6'b110010);
        while (phase != 0) cycle(1'b0, 1'b0);
        reset = 1'b1; hphi_tick = 1'b1; lfsr = lfsr_tab[4]; shb = 1'b1; hmove = 1'b1; wsync = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; hphi_tick = 1'b0; shb = 1'b0; hmove = 1'b0; wsync = 1'b0;
        cyc++;
        phase = 0;
        cur   = 0;
        check("mid_reset", 6'b010010, 6'b010010);
        go_tick(4, 1'b0, 1'b0);
        check("post_reset_k4", 6'b110010, 6'b110010);
        go_tick(16, 1'b0, 1'b0);
        check("post_reset_k16", 6'b000010, 6'b000010);

        go_tick(20, 1'b0, 1'b0);
        raw_tick(6'h3F, 1'b0);
        check("unknown_3f", 6'b000010, 6'b000010);
        raw_tick(lfsr_tab[1], 1'b0);
        check("unknown_k1", 6'b000010, 6'b000010);
        raw_tick(lfsr_tab[40], 1'b0);
        check("unknown_k40", 6'b000010, 6'b000010);

        go_tick(40, 1'b0, 1'b0);
        check("center_k40", 6'b000110, 6'b000110);
        raw_tick(lfsr_tab[4], 1'b1);
        check("wrap_with_shs", 6'b110011, 6'b110011);
        cycle(1'b0, 1'b0);
        check("wrap_with_shs_next", 6'b110010, 6'b110010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tia_horizontal_decoder.md
TIA_HORIZONTAL_DECODER -- requirements
Module: tia_horizontal_decoder

Interface
REQ-001 SHALL have parameter HMOVE_EXTEND, default 1: 1 = a latched HMOVE moves end-of-HBLANK from RHB to LRHB; 0 = HMOVE ignored for blanking.
REQ-002 SHALL have a single clock and a synchronous, active-high reset.
REQ-003 Port: clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: hphi_tick  in  1  one-clk strobe; horizontal LFSR advanced this cycle.
REQ-006 Port: lfsr  in  6  horizontal LFSR state {a,b,c,d,e,f}, a = bit 5; sampled only when hphi_tick=1.
REQ-007 Port: shb  in  1  LFSR wrap (end-of-line) flag, qualified by hphi_tick.
REQ-008 Port: hmove  in  1  one-clk HMOVE strobe.
REQ-009 Port: wsync  in  1  one-clk WSYNC strobe.
REQ-010 Port: hsync, hblank, cburst, center, rdy, line_start  out  1 each: horizontal sync, horizontal blank, colour-burst window, second half of line, CPU ready, one-clk start-of-line pulse.

Function
REQ-011 Decode SHALL occur only on cycles with hphi_tick=1; on other cycles all outputs hold, except that line_start deasserts.
REQ-012 Decoded events (LFSR index k = ticks after wrap): SHS k=4, RHS k=8, RCB k=12, RHB k=16, LRHB k=18, CNT k=36; line wrap = shb with hphi_tick.
REQ-013 Every output SHALL be registered and change exactly one clk after the decoding tick.
REQ-014 hblank SHALL be set on line wrap; it clears at RHB when hmove_latch=0 or HMOVE_EXTEND=0, otherwise at LRHB.
REQ-015 hsync SHALL be set at SHS and cleared at RHS.
REQ-016 cburst SHALL be set at RHS and cleared at RCB.
REQ-017 center SHALL be set at CNT and cleared on line wrap.
REQ-018 line_start SHALL pulse for exactly one clk after each line wrap.
REQ-019 hmove_latch (internal) SHALL be set by hmove; it clears at the tick that clears hblank. If set and clear coincide, set wins, so the latch persists into the next line.
REQ-020 rdy SHALL drop to 0 one clk after wsync and return to 1 one clk after the next line wrap. If wsync coincides with a wrap tick, rdy=0 and is held until the following wrap.
REQ-021 LFSR states matching no decode constant SHALL cause no event; shb=1 with any lfsr value counts as a wrap.
REQ-022 A wrap and a decode event on the same tick SHALL both take effect.

Reset
REQ-023 On reset, outputs SHALL be hblank=1, hsync=0, cburst=0, center=0, rdy=1, line_start=0, and hmove_latch=0.
REQ-024 Reset SHALL override all inputs, including hphi_tick, hmove and wsync in the same cycle.
REQ-025 Reset mid-line SHALL abandon any pending WSYNC or HMOVE; decoding resumes on the first tick after reset deasserts.

Structure
REQ-026 Package tia_horizontal_pkg SHALL hold:
- 6-bit LFSR decode constants HD_SHS, HD_RHS, HD_RCB, HD_RHB, HD_LRHB, HD_CNT, computed from the same LFSR sequence the horizontal LFSR produces;
- line length 57 ticks;
- clocks per tick 4.
REQ-027 Purely combinational state-to-event matching SHALL live in one sub-module, tia_horizontal_match (lfsr in, event one-hot out). Latches and rdy logic stay in the top.

Verification
REQ-028 Bench drives hphi_tick every 4 clks from a behavioural LFSR model, reset released at clk 0, no hmove/wsync -> hsync high for ticks 4..7, cburst for 8..11, hblank low from tick 16, center from tick 36; line_start every 228 clks.
REQ-029 hmove pulse at tick 2 -> hblank clears at tick 18 instead of 16, and hmove_latch is 0 afterwards. Repeat with HMOVE_EXTEND=0 -> clears at tick 16.
REQ-030 wsync at tick 30 -> rdy=0 from the next clk until one clk after the wrap at tick 56; wsync on the wrap tick -> rdy stays 0 for a full 228 clks.
REQ-031 hmove on the same clk as the LRHB tick -> hblank clears now, and the next line's hblank also ends at tick 18.
REQ-032 Reset asserted at tick 6 (hsync=1) -> next clk hsync=0, hblank=1, rdy=1. Unknown lfsr values injected on ticks -> no output change.
